// File: rtl/dv_stim_driver.sv
// dv_stim_driver: replays a preloaded table of {delay, packet} entries into a DUT
// over an access/wait handshake, once per start, then raises a sticky stim_done.
//
// Handshake: stim_access is the valid. dut_wait is the inverse of ready. A packet
// is accepted on a posedge where stim_access=1 and dut_wait=0. While dut_wait=1
// the offered packet is held stable and is never retracted.
//
// The internal state register is left visible so that checkers can be bound to it.
module dv_stim_driver #(
  parameter int    PW       = 104,
  parameter int    DW       = 16,
  parameter int    AW       = 10,
  parameter string FILENAME = "stimulus.mem"
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          start,
  input  logic          dut_wait,
  output logic          stim_access,
  output logic [PW-1:0] stim_packet,
  output logic [AW:0]   stim_count,
  output logic          stim_done
);

  localparam int DEPTH = 1 << AW;
  localparam int EW    = DW + PW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRIVE,
    S_DONE
  } state_t;

  state_t        state;
  logic [AW:0]   ptr;
  logic [DW-1:0] cnt;

  // Each entry is {delay, packet}; an all-ones delay marks the end of the table.
  logic [EW-1:0] mem [DEPTH];

  logic          accept;
  logic [AW:0]   eval_ptr;
  logic [EW-1:0] eval_entry;
  logic [DW-1:0] eval_delay;
  logic [PW-1:0] eval_payload;
  logic          eval_end;
  state_t        eval_state;
  logic          eval_access;
  logic [PW-1:0] eval_packet;
  logic [DW-1:0] eval_cnt;
  logic          eval_done;

  // Entry evaluation: look at the current entry, or the next one on an acceptance edge.
  always_comb begin
    accept       = (state == S_DRIVE) && !dut_wait;
    eval_ptr     = accept ? ptr + 1'b1 : ptr;
    eval_entry   = mem[eval_ptr[AW-1:0]];
    eval_delay   = eval_entry[EW-1:PW];
    eval_payload = eval_entry[PW-1:0];
    eval_end     = eval_ptr[AW] || (&eval_delay);
    eval_state   = S_DONE;
    eval_access  = 1'b0;
    eval_packet  = '0;
    eval_cnt     = '0;
    eval_done    = 1'b0;
    if (eval_end) begin
      eval_done = 1'b1;
    end else if (eval_delay == '0) begin
      eval_state  = S_DRIVE;
      eval_access = 1'b1;
      eval_packet = eval_payload;
    end else begin
      eval_state = S_WAIT;
      eval_cnt   = eval_delay;
    end
  end

  // Sequencer: single registered FSM driving every output.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= S_IDLE;
      ptr         <= '0;
      cnt         <= '0;
      stim_access <= 1'b0;
      stim_packet <= '0;
      stim_count  <= '0;
      stim_done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= eval_state;
            cnt         <= eval_cnt;
            stim_access <= eval_access;
            stim_packet <= eval_packet;
            stim_done   <= eval_done;
          end
        end
        S_WAIT: begin
          // The count loaded with d gives exactly d idle cycles before the drive.
          if (cnt == DW'(1)) begin
            state       <= S_DRIVE;
            cnt         <= '0;
            stim_access <= 1'b1;
            stim_packet <= eval_payload;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DRIVE: begin
          if (accept) begin
            stim_count  <= stim_count + 1'b1;
            ptr         <= eval_ptr;
            state       <= eval_state;
            cnt         <= eval_cnt;
            stim_access <= eval_access;
            stim_packet <= eval_packet;
            stim_done   <= eval_done;
          end
        end
        S_DONE: begin
          stim_access <= 1'b0;
          stim_packet <= '0;
          stim_done   <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dv_stim_driver.sv
// Bench for dv_stim_driver: tables are written into the design's table array,
// a model derives the expected packet order and idle gaps, and a negedge monitor
// scores every cycle of the handshake against those expectations.
module tb_dv_stim_driver;

  localparam int PW  = 104;
  localparam int DW  = 16;
  localparam int EW  = PW + DW;
  localparam int MAW = 4;
  localparam int SAW = 2;
  localparam logic [DW-1:0] END_DLY = '1;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic start = 1'b0;
  logic dut_wait = 1'b0;
  logic sel = 1'b0;

  logic          m_access, s_access;
  logic [PW-1:0] m_packet, s_packet;
  logic [MAW:0]  m_count;
  logic [SAW:0]  s_count;
  logic          m_done, s_done;
  logic          m_start, s_start;

  logic          mon_access;
  logic [PW-1:0] mon_packet;
  logic [MAW:0]  mon_count;
  logic          mon_done;

  assign m_start    = start & ~sel;
  assign s_start    = start & sel;
  assign mon_access = sel ? s_access : m_access;
  assign mon_packet = sel ? s_packet : m_packet;
  assign mon_count  = sel ? {{(MAW - SAW){1'b0}}, s_count} : m_count;
  assign mon_done   = sel ? s_done : m_done;

  dv_stim_driver #(.PW(PW), .DW(DW), .AW(MAW), .FILENAME("")) u_main (
    .clk(clk), .nreset(nreset), .start(m_start), .dut_wait(dut_wait),
    .stim_access(m_access), .stim_packet(m_packet), .stim_count(m_count), .stim_done(m_done)
  );

  dv_stim_driver #(.PW(PW), .DW(DW), .AW(SAW), .FILENAME("")) u_small (
    .clk(clk), .nreset(nreset), .start(s_start), .dut_wait(dut_wait),
    .stim_access(s_access), .stim_packet(s_packet), .stim_count(s_count), .stim_done(s_done)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;

  logic [PW-1:0] exp_q[$];
  int            exp_gap_q[$];
  int            exp_total = 0;
  logic [EW-1:0] tbl [16];

  int            wait_mode = 0;
  int            hold_left = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] rand_pkt();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[PW-1:0];
  endfunction

  // Reference model: walk the table until an end marker or the end of the array.
  task automatic build_model(input int depth);
    exp_q.delete();
    exp_gap_q.delete();
    for (int i = 0; i < depth; i++) begin
      if (tbl[i][EW-1:PW] == END_DLY) break;
      exp_q.push_back(tbl[i][PW-1:0]);
      exp_gap_q.push_back(int'(tbl[i][EW-1:PW]));
    end
    exp_total = exp_q.size();
  endtask

  task automatic clear_tbl();
    for (int i = 0; i < 16; i++) tbl[i] = {END_DLY, rand_pkt()};
  endtask

  // ---------------- dut_wait driver ----------------
  always @(posedge clk) begin
    #2;
    case (wait_mode)
      0: dut_wait = 1'b0;
      1: dut_wait = ($urandom_range(0, 2) == 0);
      default: begin
        dut_wait = (hold_left > 0);
        if (mon_access && hold_left > 0) hold_left--;
      end
    endcase
  end

  // ---------------- monitor ----------------
  bit            running = 0;
  bit            holding = 0;
  int            idle = 0;
  int            acc = 0;
  int            drive_cycles = 0;
  logic [PW-1:0] held_pkt = '0;

  always @(negedge clk) begin
    if (!nreset) begin
      running = 0; holding = 0; idle = 0; acc = 0; drive_cycles = 0;
      chk("rst_access", 128'(mon_access), 128'(0));
      chk("rst_packet", 128'(mon_packet), 128'(0));
      chk("rst_count", 128'(mon_count), 128'(0));
      chk("rst_done", 128'(mon_done), 128'(0));
    end else if (!running) begin
      chk("idle_access", 128'(mon_access), 128'(0));
      chk("idle_count", 128'(mon_count), 128'(0));
      chk("idle_done", 128'(mon_done), 128'(0));
      if (start) begin
        running = 1; holding = 0; idle = 0;
      end
    end else begin
      if (holding) begin
        chk("hold_access", 128'(mon_access), 128'(1));
        chk("hold_packet", 128'(mon_packet), 128'(held_pkt));
      end
      if (mon_access) begin
        drive_cycles++;
        if (!holding) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_access", 128'(mon_access), 128'(0));
          end else begin
            chk("packet", 128'(mon_packet), 128'(exp_q.pop_front()));
            chk("gap", 128'(idle), 128'(exp_gap_q.pop_front()));
          end
          idle = 0;
        end
        held_pkt = mon_packet;
        holding  = dut_wait;
      end else begin
        holding = 0;
        if (!mon_done) idle++;
      end
      chk("count", 128'(mon_count), 128'(acc));
      chk("done", 128'(mon_done), 128'(acc == exp_total));
      if (acc == exp_total) begin
        chk("done_access", 128'(mon_access), 128'(0));
        chk("done_packet", 128'(mon_packet), 128'(0));
      end
      if (mon_access && !dut_wait) acc++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reset_load(input bit use_small, input int wmode, input int hold);
    @(posedge clk); #2;
    nreset = 1'b0; start = 1'b0;
    sel = use_small; wait_mode = wmode; hold_left = hold;
    build_model(use_small ? 4 : 16);
    for (int i = 0; i < 16; i++) u_main.mem[i] = tbl[i];
    for (int i = 0; i < 4; i++) u_small.mem[i] = tbl[i];
    repeat (2) @(posedge clk);
    #2 nreset = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #2 start = 1'b0;
  endtask

  task automatic finish_run(input int exp_count, input int exp_drive);
    int c;
    for (c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (mon_done) break;
    end
    chk("done_reached", 128'(mon_done), 128'(1));
    // start after completion must not restart anything
    repeat (2) @(posedge clk);
    #2 start = 1'b1;
    repeat (3) @(posedge clk);
    #2 start = 1'b0;
    @(posedge clk); #1;
    chk("final_count", 128'(mon_count), 128'(exp_count));
    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    if (exp_drive >= 0) chk("drive_cycles", 128'(drive_cycles), 128'(exp_drive));
  endtask

  // ---------------- stimulus ----------------
  logic [PW-1:0] p0, p1, p2;

  initial begin
    // back-to-back delay-0 entries
    clear_tbl();
    p0 = rand_pkt(); p1 = rand_pkt(); p2 = rand_pkt();
    tbl[0] = {16'd0, p0}; tbl[1] = {16'd0, p1}; tbl[2] = {16'd0, p2};
    reset_load(0, 0, 0);
    pulse_start();
    finish_run(3, 3);

    // five idle cycles between two packets
    clear_tbl();
    tbl[0] = {16'd0, p0}; tbl[1] = {16'd5, p1};
    reset_load(0, 0, 0);
    pulse_start();
    finish_run(2, 2);

    // packet held under four cycles of back-pressure
    clear_tbl();
    tbl[0] = {16'd0, p0};
    reset_load(0, 2, 4);
    pulse_start();
    finish_run(1, 5);

    // end marker in entry 0
    clear_tbl();
    reset_load(0, 0, 0);
    pulse_start();
    finish_run(0, 0);

    // small table with no marker ends at the array end
    for (int i = 0; i < 4; i++) tbl[i] = {16'd0, rand_pkt()};
    reset_load(1, 0, 0);
    pulse_start();
    finish_run(4, 4);

    // leading delay on entry 0
    clear_tbl();
    tbl[0] = {16'd3, p0}; tbl[1] = {16'd1, p1};
    reset_load(0, 1, 0);
    pulse_start();
    finish_run(2, -1);

    // reset while waiting on entry 1, then replay from entry 0
    clear_tbl();
    tbl[0] = {16'd0, p0}; tbl[1] = {16'd20, p1}; tbl[2] = {16'd0, p2};
    reset_load(0, 0, 0);
    pulse_start();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (mon_count == 1) break;
    end
    chk("pre_reset_count", 128'(mon_count), 128'(1));
    repeat (3) @(posedge clk);
    #3 nreset = 1'b0;
    #1;
    chk("async_access", 128'(m_access), 128'(0));
    chk("async_packet", 128'(m_packet), 128'(0));
    chk("async_count", 128'(m_count), 128'(0));
    chk("async_done", 128'(m_done), 128'(0));
    build_model(16);
    repeat (2) @(posedge clk);
    #2 nreset = 1'b1;
    pulse_start();
    finish_run(3, 3);

    // randomized tables, random back-pressure
    for (int r = 0; r < 14; r++) begin
      bit use_small;
      int depth, n;
      use_small = (r % 7 == 6);
      depth = use_small ? 4 : 16;
      clear_tbl();
      n = ($urandom_range(0, 3) == 0) ? depth : $urandom_range(1, depth);
      for (int i = 0; i < n; i++) begin
        logic [DW-1:0] d;
        d = ($urandom_range(0, 9) < 6) ? DW'(0) : DW'($urandom_range(1, 6));
        tbl[i] = {d, rand_pkt()};
      end
      reset_load(use_small, 1, 0);
      pulse_start();
      finish_run(exp_total, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
